// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result bundle for the bit-serial adder
// SERIAL_ADDER_SUB_EN adds the sub request bit alongside the operands.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout
  );
  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );
  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder, one full-adder cell plus carry flop
// Optional SERIAL_ADDER_SUB_EN: sub=1 computes a - b as a + ~b + 1.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             bit_s;
  logic             bit_c;
  logic             last_bit;
  logic [WIDTH-1:0] b_in;
  logic             carry_in;

  // Subtraction folds into the adder by inverting B and forcing the carry-in.
  always_comb begin
    b_in     = bus.b;
    carry_in = bus.cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (bus.sub) begin
      b_in     = ~bus.b;
      carry_in = 1'b1;
    end
`endif
  end

  assign accept   = bus.start && (state_q != RUN);
  assign bit_s    = shift_a_q[0] ^ shift_b_q[0] ^ carry_q;
  assign bit_c    = (shift_a_q[0] & shift_b_q[0]) |
                    (shift_a_q[0] & carry_q) |
                    (shift_b_q[0] & carry_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;

    case (state_q)
      RUN: begin
        shift_a_d        = shift_a_q >> 1;
        shift_b_d        = shift_b_q >> 1;
        carry_d          = bit_c;
        acc_d            = acc_q >> 1;
        acc_d[WIDTH-1]   = bit_s;
        cnt_d            = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = DONE;
          sum_d   = acc_d;
          cout_d  = bit_c;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request, giving back-to-back starts.
        state_d = IDLE;
        if (accept) begin
          shift_a_d = bus.a;
          shift_b_d = b_in;
          carry_d   = carry_in;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_a_q <= '0;
      shift_b_q <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed bench for serial_adder (WIDTH=8 and WIDTH=1)
// Covers SERIAL_ADDER_SUB_EN subtraction when that macro is defined.
module tb_serial_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request on the WIDTH=8 instance and waits (bounded) for done.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output logic [7:0] s, output logic c, output int cyc);
    if8.a     = a;
    if8.b     = b;
    if8.cin   = cin;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    cyc = 1;
    while (!if8.done && cyc < 40) begin
      tick();
      cyc++;
    end
    s = if8.sum;
    c = if8.cout;
    tick();
  endtask

  task automatic test_reset();
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    if8.sub = 1'b0;
    if1.sub = 1'b0;
`endif
    tick();
    tick();
    n_cmp++;
    if ({if8.busy, if8.done, if8.sum, if8.cout} !== 11'h0) begin
      n_err++;
      $display("FAIL reset_w8: got busy=%b done=%b sum=%h cout=%b expected all 0",
               if8.busy, if8.done, if8.sum, if8.cout);
    end
    n_cmp++;
    if ({if1.busy, if1.done, if1.sum, if1.cout} !== 4'h0) begin
      n_err++;
      $display("FAIL reset_w1: got busy=%b done=%b sum=%h cout=%b expected all 0",
               if1.busy, if1.done, if1.sum, if1.cout);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int busy_cycles;
    busy_cycles = 0;
    if8.a = 8'h35; if8.b = 8'h4A; if8.cin = 1'b0; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (if8.busy) busy_cycles++;
      n_cmp++;
      if (if8.done !== 1'b0) begin
        n_err++;
        $display("FAIL basic_early_done: got done=%b at run cycle %0d expected 0", if8.done, i);
      end
      tick();
    end
    n_cmp++;
    if (busy_cycles != 8) begin
      n_err++;
      $display("FAIL basic_busy_len: got %0d expected 8", busy_cycles);
    end
    n_cmp++;
    if (if8.done !== 1'b1 || if8.busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done: got done=%b busy=%b expected done=1 busy=0", if8.done, if8.busy);
    end
    n_cmp++;
    if (if8.sum !== 8'h7F || if8.cout !== 1'b0) begin
      n_err++;
      $display("FAIL basic_sum: got sum=%h cout=%b expected sum=7f cout=0", if8.sum, if8.cout);
    end
    tick();
    n_cmp++;
    if (if8.done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_pulse: got done=%b expected 0", if8.done);
    end
  endtask

  task automatic test_carry();
    logic [7:0] s;
    logic       c;
    int         cyc;
    do_op8(8'hFF, 8'h01, 1'b0, s, c, cyc);
    n_cmp++;
    if (s !== 8'h00 || c !== 1'b1 || cyc != 9) begin
      n_err++;
      $display("FAIL carry_ff_01: got sum=%h cout=%b lat=%0d expected sum=00 cout=1 lat=9", s, c, cyc);
    end
    do_op8(8'hFF, 8'hFF, 1'b1, s, c, cyc);
    n_cmp++;
    if (s !== 8'hFF || c !== 1'b1 || cyc != 9) begin
      n_err++;
      $display("FAIL carry_ff_ff_1: got sum=%h cout=%b lat=%0d expected sum=ff cout=1 lat=9", s, c, cyc);
    end
    do_op8(8'hA5, 8'h5A, 1'b1, s, c, cyc);
    n_cmp++;
    if (s !== 8'h00 || c !== 1'b1) begin
      n_err++;
      $display("FAIL carry_a5_5a_1: got sum=%h cout=%b expected sum=00 cout=1", s, c);
    end
    do_op8(8'h00, 8'h00, 1'b1, s, c, cyc);
    n_cmp++;
    if (s !== 8'h01 || c !== 1'b0) begin
      n_err++;
      $display("FAIL carry_cin_only: got sum=%h cout=%b expected sum=01 cout=0", s, c);
    end
  endtask

  task automatic test_back_to_back();
    if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0; if8.start = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      if8.start = (i == 2);
      if8.a     = (i == 2) ? 8'h01 : 8'h10;
      if8.b     = (i == 2) ? 8'h01 : 8'h20;
      n_cmp++;
      if (if8.done !== 1'b0 || if8.busy !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_run1: got done=%b busy=%b at cycle %0d expected done=0 busy=1",
                 if8.done, if8.busy, i);
      end
      tick();
    end
    n_cmp++;
    if (if8.done !== 1'b1 || if8.sum !== 8'h30 || if8.cout !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_first: got done=%b sum=%h cout=%b expected done=1 sum=30 cout=0",
               if8.done, if8.sum, if8.cout);
    end
    if8.a = 8'h02; if8.b = 8'h03; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (if8.busy !== 1'b1 || if8.done !== 1'b0 || if8.sum !== 8'h30) begin
        n_err++;
        $display("FAIL b2b_run2: got busy=%b done=%b sum=%h at cycle %0d expected busy=1 done=0 sum=30",
                 if8.busy, if8.done, if8.sum, i);
      end
      tick();
    end
    n_cmp++;
    if (if8.done !== 1'b1 || if8.sum !== 8'h05 || if8.cout !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second: got done=%b sum=%h cout=%b expected done=1 sum=05 cout=0",
               if8.done, if8.sum, if8.cout);
    end
    tick();
  endtask

  task automatic test_async_reset();
    int         pulses;
    logic [7:0] s;
    logic       c;
    int         cyc;
    pulses = 0;
    if8.a = 8'hAA; if8.b = 8'h55; if8.cin = 1'b0; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({if8.busy, if8.done, if8.sum, if8.cout} !== 11'h0) begin
      n_err++;
      $display("FAIL async_reset: got busy=%b done=%b sum=%h cout=%b expected all 0",
               if8.busy, if8.done, if8.sum, if8.cout);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (if8.done) pulses++;
      tick();
    end
    n_cmp++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL async_no_done: got %0d pulses expected 0", pulses);
    end
    do_op8(8'h01, 8'h01, 1'b0, s, c, cyc);
    n_cmp++;
    if (s !== 8'h02 || c !== 1'b0 || cyc != 9) begin
      n_err++;
      $display("FAIL async_recover: got sum=%h cout=%b lat=%0d expected sum=02 cout=0 lat=9", s, c, cyc);
    end
  endtask

  task automatic test_width1();
    if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1; if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    n_cmp++;
    if (if1.busy !== 1'b1 || if1.done !== 1'b0) begin
      n_err++;
      $display("FAIL w1_run: got busy=%b done=%b expected busy=1 done=0", if1.busy, if1.done);
    end
    tick();
    n_cmp++;
    if (if1.done !== 1'b1 || if1.sum !== 1'b1 || if1.cout !== 1'b1) begin
      n_err++;
      $display("FAIL w1_111: got done=%b sum=%b cout=%b expected done=1 sum=1 cout=1",
               if1.done, if1.sum, if1.cout);
    end
    if1.a = 1'b1; if1.b = 1'b0; if1.cin = 1'b0; if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    tick();
    n_cmp++;
    if (if1.done !== 1'b1 || if1.sum !== 1'b1 || if1.cout !== 1'b0) begin
      n_err++;
      $display("FAIL w1_100: got done=%b sum=%b cout=%b expected done=1 sum=1 cout=0",
               if1.done, if1.sum, if1.cout);
    end
    tick();
    n_cmp++;
    if (if1.done !== 1'b0 || if1.busy !== 1'b0) begin
      n_err++;
      $display("FAIL w1_idle: got done=%b busy=%b expected 0 0", if1.done, if1.busy);
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [7:0] s;
    logic       c;
    int         cyc;
    if8.sub = 1'b1;
    do_op8(8'h10, 8'h20, 1'b0, s, c, cyc);
    n_cmp++;
    if (s !== 8'hF0 || c !== 1'b0) begin
      n_err++;
      $display("FAIL sub_10_20: got sum=%h cout=%b expected sum=f0 cout=0", s, c);
    end
    do_op8(8'h20, 8'h10, 1'b0, s, c, cyc);
    n_cmp++;
    if (s !== 8'h10 || c !== 1'b1) begin
      n_err++;
      $display("FAIL sub_20_10: got sum=%h cout=%b expected sum=10 cout=1", s, c);
    end
    do_op8(8'h33, 8'h33, 1'b0, s, c, cyc);
    n_cmp++;
    if (s !== 8'h00 || c !== 1'b1) begin
      n_err++;
      $display("FAIL sub_equal: got sum=%h cout=%b expected sum=00 cout=1", s, c);
    end
    if8.sub = 1'b0;
    do_op8(8'h10, 8'h20, 1'b0, s, c, cyc);
    n_cmp++;
    if (s !== 8'h30 || c !== 1'b0) begin
      n_err++;
      $display("FAIL sub_off_add: got sum=%h cout=%b expected sum=30 cout=0", s, c);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_async_reset();
    test_width1();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
